// File: rtl/subckt_sweep_ctrl.sv
// subckt_sweep_ctrl
//   Exhaustively sweeps all 2^NUM_IN input vectors into an external
//   combinational sub-circuit. Each vector is held for SETTLE cycles,
//   then the sub-circuit output is sampled. The block accumulates the
//   truth table and two toggle counts that act as a switching-activity proxy.
//
//   Optional build macro: SWEEP_GRAY_ORDER_EN
//     defined   -> vectors are applied in Gray-code order, k ^ (k >> 1)
//     undefined -> vectors are applied in binary order, k
//
// Parameters
//   NUM_IN  sub-circuit input count (1..6)
//   SETTLE  hold cycles before each sample (0..15)
//   CNT_W   toggle counter width (counters saturate)
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   start_i         begin a sweep (accepted in IDLE only)
//   abort_i         cancel a sweep (any non-IDLE state)
//   dut_out_i       sub-circuit output
//   vec_o           vector driven onto the sub-circuit inputs
//   busy_o          sweep in progress
//   done_o          one-cycle completion pulse
//   valid_o         results complete; held until the next start or reset
//   truth_o         bit v = sampled output for vector v
//   out_toggles_o   output changes between consecutive samples
//   in_toggles_o    summed Hamming distance between consecutive vectors
module subckt_sweep_ctrl #(
  parameter int NUM_IN = 4,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic                     dut_out_i,
  output logic [NUM_IN-1:0]        vec_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     valid_o,
  output logic [(1<<NUM_IN)-1:0]   truth_o,
  output logic [CNT_W-1:0]         out_toggles_o,
  output logic [CNT_W-1:0]         in_toggles_o
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [NUM_IN-1:0]   k;
  logic [NUM_IN-1:0]   prev_vec;
  logic                prev_out;
  logic [3:0]          settle_cnt;
  logic                last_k;
  logic                settle_end;
  logic [3:0]          hamming;

  // Map step index to applied vector.
  function automatic logic [NUM_IN-1:0] order(input logic [NUM_IN-1:0] idx);
`ifdef SWEEP_GRAY_ORDER_EN
    return idx ^ (idx >> 1);
`else
    return idx;
`endif
  endfunction

  // Saturating add. The sum is widened so that a small CNT_W cannot wrap
  // before the clamp is applied.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [3:0]       b);
    logic [CNT_W+3:0] s;
    logic [CNT_W+3:0] lim;
    s   = (CNT_W+4)'(a) + (CNT_W+4)'(b);
    lim = (CNT_W+4)'({CNT_W{1'b1}});
    return (s > lim) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign last_k     = &k;
  // With SETTLE=0 the SETTLE state is never entered, so the all-ones
  // compare value produced by the cast is harmless.
  assign settle_end = (settle_cnt == 4'(SETTLE - 1));
  assign hamming    = 4'($countones(vec_o ^ prev_vec));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and decoded outputs
  always_comb begin
    state_nxt = state;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state)
      S_IDLE: begin
        // start wins over a simultaneous abort here because abort is ignored in IDLE
        if (start_i) state_nxt = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
      end
      S_SETTLE: begin
        busy_o = 1'b1;
        if (abort_i)         state_nxt = S_IDLE;
        else if (settle_end) state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        busy_o = 1'b1;
        if (abort_i)     state_nxt = S_IDLE;
        else if (last_k) state_nxt = S_DONE;
        else             state_nxt = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
      end
      S_DONE: begin
        done_o    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: vector, truth table, counters
  always_ff @(posedge clk) begin
    if (rst) begin
      k             <= '0;
      prev_vec      <= '0;
      prev_out      <= 1'b0;
      settle_cnt    <= '0;
      vec_o         <= '0;
      valid_o       <= 1'b0;
      truth_o       <= '0;
      out_toggles_o <= '0;
      in_toggles_o  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            k             <= '0;
            vec_o         <= order('0);
            settle_cnt    <= '0;
            valid_o       <= 1'b0;
            truth_o       <= '0;
            out_toggles_o <= '0;
            in_toggles_o  <= '0;
          end
        end
        S_SETTLE: begin
          if (abort_i) begin
            vec_o   <= '0;
            valid_o <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        S_SAMPLE: begin
          if (abort_i) begin
            vec_o   <= '0;
            valid_o <= 1'b0;
          end else begin
            truth_o[vec_o] <= dut_out_i;
            prev_out       <= dut_out_i;
            prev_vec       <= vec_o;
            // The first sample has no predecessor to compare against.
            if (k != '0) begin
              out_toggles_o <= sat_add(out_toggles_o, {3'b000, dut_out_i ^ prev_out});
              in_toggles_o  <= sat_add(in_toggles_o, hamming);
            end
            if (last_k) begin
              valid_o <= 1'b1;
              vec_o   <= '0;
            end else begin
              k          <= k + 1'b1;
              vec_o      <= order(k + 1'b1);
              settle_cnt <= '0;
            end
          end
        end
        S_DONE: begin
          if (abort_i) valid_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_subckt_sweep_ctrl.sv
// Scoreboard bench for subckt_sweep_ctrl. There are three instances:
//   d=0: SETTLE=1, CNT_W=8
//   d=1: SETTLE=0, CNT_W=2 (saturation)
//   d=2: SETTLE=3, CNT_W=8
// Only one instance sweeps at a time, so a single expectation queue serves all three.
module tb_subckt_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_s [3];
  logic        abort_s [3];
  logic        dout_s  [3];
  logic [3:0]  vec_s   [3];
  logic        busy_s  [3];
  logic        done_s  [3];
  logic        valid_s [3];
  logic [15:0] truth_s [3];
  logic [7:0]  ot_s    [3];
  logic [7:0]  it_s    [3];
  logic [15:0] tt_s    [3];
  logic [1:0]  ot_b, it_b;
  logic [15:0] ref_tt;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  typedef struct {
    int          dut;
    logic [15:0] truth;
    int          ot;
    int          it;
    int          start;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sub-circuit models: each is a combinational truth-table lookup.
  assign dout_s[0] = tt_s[0][vec_s[0]];
  assign dout_s[1] = tt_s[1][vec_s[1]];
  assign dout_s[2] = tt_s[2][vec_s[2]];
  assign ot_s[1]   = {6'd0, ot_b};
  assign it_s[1]   = {6'd0, it_b};

  subckt_sweep_ctrl #(.NUM_IN(4), .SETTLE(1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .start_i(start_s[0]), .abort_i(abort_s[0]),
    .dut_out_i(dout_s[0]), .vec_o(vec_s[0]), .busy_o(busy_s[0]),
    .done_o(done_s[0]), .valid_o(valid_s[0]), .truth_o(truth_s[0]),
    .out_toggles_o(ot_s[0]), .in_toggles_o(it_s[0]));

  subckt_sweep_ctrl #(.NUM_IN(4), .SETTLE(0), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .start_i(start_s[1]), .abort_i(abort_s[1]),
    .dut_out_i(dout_s[1]), .vec_o(vec_s[1]), .busy_o(busy_s[1]),
    .done_o(done_s[1]), .valid_o(valid_s[1]), .truth_o(truth_s[1]),
    .out_toggles_o(ot_b), .in_toggles_o(it_b));

  subckt_sweep_ctrl #(.NUM_IN(4), .SETTLE(3), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .start_i(start_s[2]), .abort_i(abort_s[2]),
    .dut_out_i(dout_s[2]), .vec_o(vec_s[2]), .busy_o(busy_s[2]),
    .done_o(done_s[2]), .valid_o(valid_s[2]), .truth_o(truth_s[2]),
    .out_toggles_o(ot_s[2]), .in_toggles_o(it_s[2]));

  function automatic int settle_of(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic int cmax_of(input int d);
    return (d == 1) ? 3 : 255;
  endfunction

  function automatic logic [3:0] ord(input int k);
    logic [3:0] kk;
    kk = 4'(k);
`ifdef SWEEP_GRAY_ORDER_EN
    return kk ^ (kk >> 1);
`else
    return kk;
`endif
  endfunction

  // Reference model: walk the sweep order and apply the counting rules directly.
  function automatic exp_t model(input int d, input logic [15:0] tt, input int s);
    exp_t       e;
    logic [3:0] v, pv;
    int         cm;
    cm      = cmax_of(d);
    e.dut   = d;
    e.truth = '0;
    e.ot    = 0;
    e.it    = 0;
    e.start = s;
    e.lat   = 16 * (settle_of(d) + 1) + 1;
    pv      = '0;
    for (int k = 0; k < 16; k++) begin
      v = ord(k);
      e.truth[v] = tt[v];
      if (k > 0) begin
        e.ot = e.ot + ((tt[v] != tt[pv]) ? 1 : 0);
        e.it = e.it + $countones(v ^ pv);
        if (e.ot > cm) e.ot = cm;
        if (e.it > cm) e.it = cm;
      end
      pv = v;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic longint out_word(input int d);
    return longint'({vec_s[d], busy_s[d], done_s[d], valid_s[d],
                     truth_s[d], ot_s[d], it_s[d]});
  endfunction

  // Monitor: each completion pulse is checked against the oldest expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (done_s[d] === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_dut",        d,                   mon_e.dut);
          chk("truth",         truth_s[d],          mon_e.truth);
          chk("out_toggles",   ot_s[d],             mon_e.ot);
          chk("in_toggles",    it_s[d],             mon_e.it);
          chk("done_latency",  cyc - mon_e.start,   mon_e.lat);
          chk("valid_at_done", valid_s[d],          1);
          chk("busy_at_done",  busy_s[d],           0);
        end
      end
    end
  end

  // One sweep on instance d. The task returns on the negedge of the expected
  // done cycle when the sweep completes, or one cycle after the abort.
  // If extra is set, start pulses are issued while the sweep is busy.
  task automatic sweep(input int d, input logic [15:0] tt, input int abort_j,
                       input bit extra);
    int s, lat;
    lat     = 16 * (settle_of(d) + 1) + 1;
    tt_s[d] = tt;
    @(negedge clk);
    start_s[d] = 1'b1;
    s = cyc;
    if (abort_j < 0) sb.push_back(model(d, tt, s));
    for (int j = 1; j <= lat; j++) begin
      @(negedge clk);
      if (abort_j >= 0 && j == abort_j + 1) begin
        chk("abort_busy",  busy_s[d],  0);
        chk("abort_vec",   vec_s[d],   0);
        chk("abort_valid", valid_s[d], 0);
        chk("abort_done",  done_s[d],  0);
        abort_s[d] = 1'b0;
        break;
      end
      if (j == 3) begin
        chk("valid_low_in_sweep", valid_s[d], 0);
        chk("busy_in_sweep",      busy_s[d],  1);
      end
      start_s[d] = extra && (j % 5 == 0) && (j < lat - 1);
      abort_s[d] = (j == abort_j);
    end
    start_s[d] = 1'b0;
    abort_s[d] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] vv;
    int         ot_ref, it_ref;
    for (int d = 0; d < 3; d++) begin
      start_s[d] = 1'b0;
      abort_s[d] = 1'b0;
      tt_s[d]    = '0;
    end
    for (int v = 0; v < 16; v++) begin
      vv = 4'(v);
      ref_tt[v] = (vv[3] | (vv[0] ^ vv[2])) & (vv[0] | (vv[1] & (vv[0] ^ vv[2])));
    end
`ifdef SWEEP_GRAY_ORDER_EN
    ot_ref = 8;  it_ref = 15;
`else
    ot_ref = 11; it_ref = 26;
`endif

    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) chk("reset_state", out_word(d), 0);

    // Reference sub-circuit, then an immediate back-to-back repeat.
    sweep(0, ref_tt, -1, 1'b0);
    chk("ref_truth",  truth_s[0], 16'hEA4A);
    chk("ref_out_tg", ot_s[0],    ot_ref);
    chk("ref_in_tg",  it_s[0],    it_ref);
    sweep(0, ref_tt, -1, 1'b0);
    chk("b2b_truth",  truth_s[0], 16'hEA4A);

    // Random tables, with some sweeps receiving ignored start pulses.
    for (int i = 0; i < 6; i++) begin
      sweep(0, 16'($urandom), -1, (i % 2) == 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    @(negedge clk);
    chk("valid_held", valid_s[0], 1);

    // Abort during vector 7, then a normal sweep.
    sweep(0, 16'($urandom), 15, 1'b0);
    sweep(0, ref_tt, -1, 1'b0);
    // Abort on the final sample must beat completion.
    sweep(0, 16'($urandom), 32, 1'b0);
    sweep(0, 16'($urandom), $urandom_range(1, 31), 1'b0);
    sweep(0, 16'($urandom), -1, 1'b0);

    // Synchronous reset in the middle of a sweep.
    tt_s[0] = 16'($urandom);
    @(negedge clk); start_s[0] = 1'b1;
    @(negedge clk); start_s[0] = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_state", out_word(0), 0);
    rst = 1'b0;
    sweep(0, 16'($urandom), -1, 1'b0);

    // SETTLE=0, CNT_W=2: out = n1 saturates both counters.
    sweep(1, 16'hAAAA, -1, 1'b0);
    chk("sat_out_tg", ot_s[1], 3);
    chk("sat_in_tg",  it_s[1], 3);
    sweep(1, ref_tt, -1, 1'b1);
    sweep(1, 16'($urandom), -1, 1'b0);

    // SETTLE=3.
    sweep(2, ref_tt, -1, 1'b0);
    chk("s3_truth", truth_s[2], 16'hEA4A);
    sweep(2, 16'($urandom), -1, 1'b1);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/subckt_sweep_ctrl.md
# subckt_sweep_ctrl

Sequencer that exhaustively drives every input combination into an external NUM_IN-input combinational sub-circuit under power evaluation, waits a programmable settle time, samples its single output, and accumulates the truth table plus input/output toggle counts as a switching-activity proxy. It sits between the experiment harness (start/abort, result readout) and one rewritten or reference sub-circuit instance whose inputs it owns.

## Interface
- NUM_IN, 4: sub-circuit input count; sweep length is 2^NUM_IN vectors (legal 1..6).
- SETTLE, 1: cycles each vector is held before sampling (legal 0..15).
- CNT_W, 8: toggle counter width.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  begin sweep; honoured only in IDLE.
- abort_i  in  1  cancel sweep; honoured in any non-IDLE state.
- dut_out_i  in  1  sub-circuit output.
- vec_o  out  NUM_IN  vector driven to sub-circuit inputs (bit 0 → first input).
- busy_o  out  1  sweep in progress.
- done_o  out  1  one-cycle pulse at sweep completion.
- valid_o  out  1  results below are complete and stable.
- truth_o  out  2^NUM_IN  bit v = sampled output for vector v.
- out_toggles_o  out  CNT_W  output changes between consecutive samples.
- in_toggles_o  out  CNT_W  summed Hamming distance between consecutive applied vectors.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- Reset: state IDLE; vec_o=0, busy_o=0, done_o=0, valid_o=0, truth_o=0, both counters 0.
- IDLE: start_i=1 → SETTLE; step index k=0, vec_o=order(0), truth_o/counters cleared, valid_o=0, busy_o=1.
- SETTLE: hold vec_o for SETTLE cycles (SETTLE=0 skips directly to SAMPLE), then SAMPLE.
- SAMPLE: truth_o[vec_o] <= dut_out_i; if k>0, out_toggles += (dut_out_i != previous sample), in_toggles += popcount(vec_o ^ previous vector). If k=2^NUM_IN−1 → DONE; else k++, vec_o=order(k), → SETTLE.
- DONE: done_o=1 and valid_o=1 for this cycle, busy_o=0, → IDLE. valid_o remains 1 until next start or reset.
- Counters saturate at 2^CNT_W−1; no wrap.
- abort_i (non-IDLE): next cycle IDLE, busy_o=0, valid_o=0, no done_o, vec_o returns to 0; partial results undefined. abort_i wins over same-cycle completion.
- start_i while busy_o=1: ignored. start_i and abort_i together in IDLE: start wins.
- rst mid-sweep: identical to reset values above, regardless of state.

## Timing
- Each vector occupies SETTLE+1 cycles; vec_o changes only on leaving SAMPLE.
- start_i accepted at edge t: vec_o/busy_o valid after t; first sample at edge t+SETTLE+1.
- done_o asserted 2^NUM_IN·(SETTLE+1)+1 cycles after the start edge; busy_o falls on that same edge.
- Back-to-back: start_i high in the cycle after done_o begins a new sweep immediately.
- dut_out_i must be stable SETTLE cycles after vec_o changes; it is sampled only in SAMPLE.

## Configuration
- SWEEP_GRAY_ORDER_EN defined: order(k)=k^(k>>1) (Gray code); in_toggles_o ends at 2^NUM_IN−1.
- Undefined: order(k)=k (binary); in_toggles_o ends at 2^(NUM_IN+1)−NUM_IN−2 (26 for NUM_IN=4).
- truth_o is independent of ordering.

## Test plan
- Reference sub-circuit model out=(n4|(n1^n3))&(n1|(n2&(n1^n3))), NUM_IN=4, SETTLE=1, start → done_o at cycle 33, truth_o=0xEA4A, out_toggles_o=11/in_toggles_o=26 (binary) or 8/15 (Gray).
- Same stimulus with SETTLE=0 → done_o at cycle 17, identical results; SETTLE=3 → cycle 65.
- abort_i during vector 7 → busy_o=0 next cycle, vec_o=0, valid_o=0, no done_o; following start completes normally.
- rst asserted mid-sweep → all outputs 0 next cycle; start_i pulses while busy_o=1 → no restart, done_o timing unchanged.
- CNT_W=2 with constant-toggling model (out=n1) → out_toggles_o saturates at 3, in_toggles_o at 3.
- Back-to-back: start_i in the done_o cycle's successor → second sweep results identical, valid_o low during second sweep.
